// File: rtl/gat_bram_load_bridge.sv
// gat_bram_load_bridge: host-to-core BRAM bridge for the GAT accelerator.
// Decodes host byte-addressed writes into per-channel word-addressed BRAM
// write strobes (payload truncated to DATA_W), tracks per-channel load counts
// with an EMPTY/LOADING/DONE FSM, and provides a latency-tracked readback path.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   soft_clr                      synchronous clear for a new load session
//   cfg_expected, host_load_done  per-channel expected count / manual done
//   host_ena/wea/addr/din         host write port
//   bram_ena/wea/addra/din        per-channel BRAM write port (registered)
//   load_done, all_load_done      per-channel / global done status
//   err_range, err_overflow       sticky reject flags
//   dbg_status                    packed status word
//   rd_en, rd_addr                readback request
//   core_rd_addr, core_rd_data    core BRAM read port (addr is combinational)
//   rd_data, rd_valid             registered readback result
module gat_bram_load_bridge #(
  parameter int unsigned TOP_WIDTH   = 32,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_W      = 20,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned CH_SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned HOST_ADDR_W = ADDR_W + CH_SEL_W + 2,
  parameter int unsigned CNT_W       = ADDR_W + 1,
  parameter int unsigned AUTO_DONE   = 1,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned RD_DATA_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      soft_clr,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_expected,
  input  logic [NUM_CH-1:0]         host_load_done,
  input  logic                      host_ena,
  input  logic                      host_wea,
  input  logic [HOST_ADDR_W-1:0]    host_addr,
  input  logic [TOP_WIDTH-1:0]      host_din,
  output logic [NUM_CH-1:0]         bram_ena,
  output logic [NUM_CH-1:0]         bram_wea,
  output logic [NUM_CH*ADDR_W-1:0]  bram_addra,
  output logic [NUM_CH*DATA_W-1:0]  bram_din,
  output logic [NUM_CH-1:0]         load_done,
  output logic                      all_load_done,
  output logic                      err_range,
  output logic                      err_overflow,
  output logic [TOP_WIDTH-1:0]      dbg_status,
  input  logic                      rd_en,
  input  logic [ADDR_W+1:0]         rd_addr,
  output logic [ADDR_W-1:0]         core_rd_addr,
  input  logic [RD_DATA_W-1:0]      core_rd_data,
  output logic [TOP_WIDTH-1:0]      rd_data,
  output logic                      rd_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_DONE    = 2'd2
  } ch_state_e;

  ch_state_e        state_q [NUM_CH];
  ch_state_e        state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [CNT_W-1:0] exp_q   [NUM_CH];
  logic [CNT_W-1:0] exp_d   [NUM_CH];
  logic [CNT_W-1:0] exp_eff;
  logic [NUM_CH-1:0] fwd_d;
  logic [NUM_CH-1:0] load_done_d;
  logic              err_range_d;
  logic              err_overflow_d;
  logic [TOP_WIDTH-1:0] dbg_d;

  logic                wr_acc;
  logic [CH_SEL_W-1:0] wr_ch;
  logic [ADDR_W-1:0]   wr_word;
  logic [RD_LAT-1:0]   rd_vld_sr;
  logic                unused_ok;

  // Host address decode; byte offset bits and payload MSBs are intentionally dropped.
  assign wr_acc       = host_ena & host_wea;
  assign wr_ch        = host_addr[HOST_ADDR_W-1:ADDR_W+2];
  assign wr_word      = host_addr[ADDR_W+1:2];
  assign core_rd_addr = rd_addr[ADDR_W+1:2];
  assign unused_ok    = ^{host_addr[1:0], host_din, rd_addr[1:0], core_rd_data};

  // Channel FSMs, counters and reject flags (next-state).
  always_comb begin
    err_range_d    = err_range;
    err_overflow_d = err_overflow;
    fwd_d          = '0;
    exp_eff        = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      exp_d[c]   = exp_q[c];
    end

    if (soft_clr) begin
      // Clear wins over any write or manual done in the same cycle.
      err_range_d    = 1'b0;
      err_overflow_d = 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_d[c] = ST_EMPTY;
        cnt_d[c]   = '0;
        exp_d[c]   = '0;
      end
    end else begin
      if (wr_acc && (32'(wr_ch) >= NUM_CH)) err_range_d = 1'b1;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (wr_acc && (32'(wr_ch) == c)) begin
          if (state_q[c] == ST_DONE) begin
            err_overflow_d = 1'b1;
          end else begin
            fwd_d[c] = 1'b1;
            cnt_d[c] = (cnt_q[c] == CNT_MAX) ? cnt_q[c] : cnt_q[c] + CNT_W'(1);
            // Expected count is captured on the first write of the session.
            exp_eff  = (state_q[c] == ST_EMPTY) ? cfg_expected[c*CNT_W +: CNT_W] : exp_q[c];
            exp_d[c] = exp_eff;
            if ((AUTO_DONE != 0) && (exp_eff != '0) && (cnt_d[c] == exp_eff))
              state_d[c] = ST_DONE;
            else
              state_d[c] = ST_LOADING;
          end
        end
        if (host_load_done[c]) state_d[c] = ST_DONE;
      end
    end

    for (int unsigned c = 0; c < NUM_CH; c++)
      load_done_d[c] = (state_d[c] == ST_DONE);

    dbg_d                 = '0;
    dbg_d[NUM_CH-1:0]     = load_done_d;
    dbg_d[16]             = err_range_d;
    dbg_d[17]             = err_overflow_d;
    dbg_d[31]             = &load_done_d;
  end

  // Write-side state and the one-stage BRAM write pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_EMPTY;
        cnt_q[c]   <= '0;
        exp_q[c]   <= '0;
      end
      bram_ena      <= '0;
      bram_wea      <= '0;
      bram_addra    <= '0;
      bram_din      <= '0;
      load_done     <= '0;
      all_load_done <= 1'b0;
      err_range     <= 1'b0;
      err_overflow  <= 1'b0;
      dbg_status    <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        exp_q[c]   <= exp_d[c];
        if (fwd_d[c]) begin
          bram_addra[c*ADDR_W +: ADDR_W] <= wr_word;
          bram_din[c*DATA_W +: DATA_W]   <= host_din[DATA_W-1:0];
        end
      end
      bram_ena      <= fwd_d;
      bram_wea      <= fwd_d;
      load_done     <= load_done_d;
      all_load_done <= &load_done_d;
      err_range     <= err_range_d;
      err_overflow  <= err_overflow_d;
      dbg_status    <= dbg_d;
    end
  end

  // Readback: valid shift register tracks requests through the core BRAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_sr <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_vld_sr <= RD_LAT'({rd_vld_sr, rd_en});
      rd_valid  <= rd_vld_sr[RD_LAT-1];
      if (rd_vld_sr[RD_LAT-1]) rd_data <= TOP_WIDTH'(core_rd_data);
    end
  end

endmodule
